// File: rtl/writeback_pkg.sv
// Shared types and constants for the LC-3 writeback stage and its register file.
package writeback_pkg;

  localparam int RF_DEPTH = 8;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;

  // Result source select driven on W_Control.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  // Condition codes, ordered {N,Z,P}.
  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  // Condition code for a value being written back.
  function automatic logic [2:0] psr_of(input logic [DATA_W-1:0] data);
    if (data[DATA_W-1])   return PSR_N;
    else if (data == '0)  return PSR_Z;
    else                  return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low reset that loads every entry with RESET_VAL.
module lc3_regfile
  import writeback_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clock_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [DATA_W-1:0] rf_d [RF_DEPTH];

  // Next-state: only the addressed entry changes, and only when written.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (we_i) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  // Storage update; reset wins over a simultaneous write.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (!rst_n_i) rf_q[i] <= RESET_VAL;
      else          rf_q[i] <= rf_d[i];
    end
  end

  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: selects the result, writes it into the register file,
// updates the {N,Z,P} condition codes and serves the two operand read ports.
// Optional same-cycle forwarding of the write data onto the read ports is
// compiled in when LC3_WRITEBACK_BYPASS_EN is defined.
module lc3_writeback
  import writeback_pkg::*;
#(
  parameter logic [DATA_W-1:0] REG_RESET_VAL = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] npc,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  logic [DATA_W-1:0] dr_in;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [2:0]        psr_q;
  logic [2:0]        psr_d;

  // Result source mux.
  always_comb begin
    dr_in = aluout;
    case (wb_sel_e'(W_Control))
      WB_ALU: dr_in = aluout;
      WB_MEM: dr_in = memout;
      WB_PC:  dr_in = pcout;
      WB_NPC: dr_in = npc;
      default: dr_in = aluout;
    endcase
  end

  lc3_regfile #(
    .RESET_VAL (REG_RESET_VAL)
  ) u_regfile (
    .clock_i  (clock),
    .rst_n_i  (reset),
    .we_i     (enable_writeback),
    .waddr_i  (dr),
    .wdata_i  (dr_in),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Condition codes follow the value written; held when nothing is written.
  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) psr_d = psr_of(dr_in);
  end

  // Condition code register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) psr_q <= 3'b000;
    else        psr_q <= psr_d;
  end

  assign psr = psr_q;

`ifdef LC3_WRITEBACK_BYPASS_EN
  // Forward the in-flight write to a matching read port in the same cycle.
  always_comb begin
    VSR1 = rd1;
    VSR2 = rd2;
    if (enable_writeback && reset && (sr1 == dr)) VSR1 = dr_in;
    if (enable_writeback && reset && (sr2 == dr)) VSR2 = dr_in;
  end
`else
  // Plain write-then-read: a write shows up on the read ports the next cycle.
  always_comb begin
    VSR1 = rd1;
    VSR2 = rd2;
  end
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback, using a reference model and a
// scoreboard of post-edge expectations.
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [1:0]  W_Control = 2'd0;
  logic [15:0] aluout = '0, memout = '0, pcout = '0, npc = '0;
  logic [2:0]  sr1 = '0, sr2 = '0, dr = '0;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  p;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_rf [8];
  logic [2:0]  m_psr;
  bit          m_valid = 0;

  lc3_writeback #(.REG_RESET_VAL(16'h0000)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .npc              (npc),
    .sr1              (sr1),
    .sr2              (sr2),
    .dr               (dr),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mux(input logic [1:0] wc, input logic [15:0] a,
                                          input logic [15:0] m, input logic [15:0] p,
                                          input logic [15:0] n);
    case (wc)
      2'd0: return a;
      2'd1: return m;
      2'd2: return p;
      default: return n;
    endcase
  endfunction

  function automatic logic [2:0] ref_psr(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  // One clock cycle: drive, check same-cycle reads, update model, push the
  // post-edge expectation, then pop and compare after the edge.
  task automatic cycle(input string tag, input bit rst_n, input bit en,
                       input logic [1:0] wc, input logic [15:0] a, input logic [15:0] m,
                       input logic [15:0] p, input logic [15:0] n,
                       input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
    logic [15:0] din, e1, e2;
    exp_t e;
    exp_t got;
    @(negedge clock);
    reset = rst_n; enable_writeback = en; W_Control = wc;
    aluout = a; memout = m; pcout = p; npc = n;
    sr1 = s1; sr2 = s2; dr = d;
    #1;
    din = ref_mux(wc, a, m, p, n);
    if (m_valid) begin
      e1 = m_rf[s1];
      e2 = m_rf[s2];
`ifdef LC3_WRITEBACK_BYPASS_EN
      if (en && rst_n && s1 == d) e1 = din;
      if (en && rst_n && s2 == d) e2 = din;
`endif
      check({tag, "/pre_vsr1"}, VSR1, e1);
      check({tag, "/pre_vsr2"}, VSR2, e2);
      check({tag, "/pre_psr"}, {13'd0, psr}, {13'd0, m_psr});
    end
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_psr = 3'b000;
      m_valid = 1;
    end else if (en) begin
      m_rf[d] = din;
      m_psr = ref_psr(din);
    end
    if (m_valid) begin
      e.v1 = m_rf[s1]; e.v2 = m_rf[s2]; e.p = m_psr; e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check({got.tag, "/vsr1"}, VSR1, got.v1);
      check({got.tag, "/vsr2"}, VSR2, got.v2);
      check({got.tag, "/psr"}, {13'd0, psr}, {13'd0, got.p});
    end
  endtask

  task automatic write(input string tag, input logic [2:0] d, input logic [15:0] v,
                       input logic [2:0] s1, input logic [2:0] s2);
    cycle(tag, 1, 1, 2'd0, v, 16'h0, 16'h0, 16'h0, s1, s2, d);
  endtask

  task automatic idle(input string tag, input logic [2:0] s1, input logic [2:0] s2);
    cycle(tag, 1, 0, 2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, s1, s2, 3'd0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++) idle(tag, 3'(i), 3'(i + 4));
  endtask

  initial begin
    // Reset held two cycles while a write is requested.
    repeat (2) cycle("reset", 0, 1, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd3, 3'd0, 3'd3);
    read_all("reset_rd");

    // Every result source into R1.
    for (int w = 0; w < 4; w++)
      cycle($sformatf("src%0d", w), 1, 1, 2'(w), 16'h0005, 16'h8000, 16'h3000, 16'h3001,
            3'd1, 3'd0, 3'd1);
    idle("src_after", 3'd1, 3'd1);

    // Zero flag, then hold with enable low.
    write("zero", 3'd2, 16'h0000, 3'd2, 3'd1);
    cycle("hold", 1, 0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    idle("hold2", 3'd2, 3'd1);

    // Same-address read during a write.
    write("r4_aa", 3'd4, 16'h00AA, 3'd0, 3'd0);
    write("r4_bb", 3'd4, 16'h00BB, 3'd4, 3'd4);
    idle("r4_after", 3'd4, 3'd4);

    // Reset lands on the R5 write.
    for (int i = 0; i < 5; i++) write($sformatf("ms_w%0d", i), 3'(i), 16'h1111 * 16'(i + 1), 3'(i), 3'd5);
    cycle("ms_rst", 0, 1, 2'd0, 16'h6666, 16'h0, 16'h0, 16'h0, 3'd5, 3'd0, 3'd5);
    read_all("ms_rd");

    // Back-to-back writes to R7.
    write("b2b_1", 3'd7, 16'h7FFF, 3'd0, 3'd7);
    write("b2b_2", 3'd7, 16'hFFFE, 3'd0, 3'd7);
    idle("b2b_rd", 3'd0, 3'd7);

    // Random mix.
    for (int i = 0; i < 40; i++)
      cycle("rand", 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), 16'($urandom),
            (i % 7 == 0) ? 16'h0000 : 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    read_all("final_rd");

    if (sb_q.size() != 0) check("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
LC3_WRITEBACK -- requirements
Module: lc3_writeback

Interface
REQ-001 SHALL have parameter REG_RESET_VAL, default 16'h0000, the value loaded into every register-file entry on reset.
REQ-002 SHALL have port clock, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL have port enable_writeback, input, 1, write qualifier for the current cycle.
REQ-005 SHALL have port W_Control, input, 2, result source select.
REQ-006 SHALL have ports aluout, memout, pcout and npc, each input, 16, the candidate write data.
REQ-007 SHALL have ports sr1 and sr2, each input, 3, the register-file read addresses.
REQ-008 SHALL have port dr, input, 3, the register-file write address.
REQ-009 SHALL have ports VSR1 and VSR2, each output, 16, read data for sr1 and sr2.
REQ-010 SHALL have port psr, output, 3, the condition codes {N,Z,P}.

Function
REQ-011 SHALL form DR_in combinationally from W_Control: 0 selects aluout, 1 selects memout, 2 selects pcout, 3 selects npc.
REQ-012 SHALL, on a rising edge with reset=1 and enable_writeback=1, write DR_in to register dr.
REQ-013 SHALL, in that same cycle, load psr with 3'b100 if DR_in[15]=1, 3'b010 if DR_in=0, and 3'b001 otherwise.
REQ-014 SHALL, when enable_writeback=0, hold both the register file and psr unchanged, irrespective of W_Control, dr and the data inputs.
REQ-015 SHALL read VSR1 and VSR2 combinationally (zero latency) from the register file at sr1 and sr2.
REQ-016 SHALL make a write visible on VSR1/VSR2 one cycle after the write edge (write-then-read order), unless the bypass in REQ-022 is compiled in.
REQ-017 SHALL return the same stored value on VSR1 and VSR2 when sr1=sr2.
REQ-018 SHALL, when dr equals sr1 and/or sr2 without bypass, present the pre-write value during the write cycle and the new value afterwards.
REQ-019 SHALL permit a write every cycle; back-to-back writes to the same dr leave only the last value, and psr reflects the last write.

Reset
REQ-020 SHALL, on a rising edge with reset=0, set all 8 registers to REG_RESET_VAL and psr to 3'b000; reset takes priority over a simultaneous enable_writeback=1, so no write occurs.
REQ-021 SHALL let a reset asserted mid-stream discard that cycle's write, with the first post-reset write occurring on the first edge where reset=1 and enable_writeback=1.

Configuration
REQ-022 SHALL, when macro LC3_WRITEBACK_BYPASS_EN is defined, drive VSR1 (VSR2) with DR_in whenever enable_writeback=1, reset=1 and sr1=dr (sr2=dr); this is same-cycle forwarding.
REQ-023 SHALL, when LC3_WRITEBACK_BYPASS_EN is undefined, contain no forwarding logic and behave exactly as REQ-015 to REQ-018.

Structure
REQ-024 SHALL take from shared package writeback_pkg:
- W_Control enum: WB_ALU=0, WB_MEM=1, WB_PC=2, WB_NPC=3
- RF_DEPTH=8, DATA_W=16, ADDR_W=3
- psr encodings PSR_N/PSR_Z/PSR_P
REQ-025 SHALL instantiate one sub-module, lc3_regfile, providing 8x16 storage with two asynchronous read ports, one synchronous write port and synchronous active-low reset.
REQ-026 SHALL keep the DR_in mux, the psr register and the bypass logic in lc3_writeback itself.

Verification
REQ-027 Reset: reset=0 for 2 cycles with enable_writeback=1, dr=3, aluout=16'h1234 -> all registers read 16'h0000 and psr=3'b000.
REQ-028 Source select: dr=1, enable_writeback=1, aluout=16'h0005, memout=16'h8000, pcout=16'h3000, npc=16'h3001, W_Control stepped 0..3 with sr1=1 -> next-cycle VSR1 reads 16'h0005, 16'h8000, 16'h3000, 16'h3001 in turn, and psr reads 001, 100, 001, 001.
REQ-029 Zero flag and hold: write 16'h0000 to R2 -> psr=3'b010; then enable_writeback=0 with aluout=16'hFFFF -> R2 stays 16'h0000 and psr stays 3'b010.
REQ-030 Same-address read during write: R4=16'h00AA, then write 16'h00BB to R4 with sr1=sr2=4 -> VSR1=VSR2=16'h00AA in the write cycle without macro, 16'h00BB with LC3_WRITEBACK_BYPASS_EN, and 16'h00BB the next cycle in both builds.
REQ-031 Reset mid-stream: writes to R0..R7 every cycle, with reset=0 asserted at the R5 edge -> R5 is not written, and all registers read 16'h0000 afterwards.
REQ-032 Back-to-back writes: R7 written 16'h7FFF then 16'hFFFE on consecutive cycles -> VSR2 (sr2=7) reads 16'hFFFE and psr=3'b100.
